// File: rtl/regfile_req_ctrl.sv
// regfile_req_ctrl: request controller in front of the flip-flop register file.
// Commands arrive on a valid/ready stream and wait in a 2-entry FIFO. Each one
// becomes a single-cycle rf_wr/rf_rd strobe. The file's combinational dout/error
// is captured into a response register returned in command order.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = FIFO not full)
//   cmd_wr, cmd_addr, cmd_data     command payload (1 = write)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_err              read data (0 for writes), captured error
//   rf_din, rf_addr, rf_wr, rf_rd  register file request, driven from FIFO head
//   rf_dout, rf_error              register file combinational outputs
//   err_cnt                        saturating count of erroring issues
//
// Build option: define RFC_ERR_CNT_EN to implement err_cnt; otherwise it is tied to 0.
module regfile_req_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wr,
    output logic              rf_rd,
    input  logic [DATA_W-1:0] rf_dout,
    input  logic              rf_error,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;

    // Command FIFO storage, reset so the head never drives X onto rf_addr/rf_din
    logic [1:0]             fifo_wr;
    logic [1:0][ADDR_W-1:0] fifo_addr;
    logic [1:0][DATA_W-1:0] fifo_data;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign push  = cmd_valid && !full;
    assign pop   = (state == ISSUE);

    assign cmd_ready = !full;
    assign rsp_valid = (state == RESP);

    // Register file request from the FIFO head; strobes decode straight from state
    assign rf_addr = fifo_addr[rd_ptr];
    assign rf_din  = fifo_data[rd_ptr];
    assign rf_wr   = (state == ISSUE) && fifo_wr[rd_ptr];
    assign rf_rd   = (state == ISSUE) && !fifo_wr[rd_ptr];

    // FIFO pointers, occupancy and storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_wr   <= '0;
            fifo_addr <= '0;
            fifo_data <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr[wr_ptr]   <= cmd_wr;
                fifo_addr[wr_ptr] <= cmd_addr;
                fifo_data[wr_ptr] <= cmd_data;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer and response register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data <= fifo_wr[rd_ptr] ? '0 : rf_dout;
                    rsp_err  <= rf_error;
                    state    <= RESP;
                end
                RESP: begin
                    // A command pushed during the handshake cycle is issued next
                    if (rsp_ready) begin
                        state <= (!empty || push) ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RFC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Saturating count of issues that saw rf_error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else if ((state == ISSUE) && rf_error && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
